// File: rtl/ibis_video_sequencer_if.sv
// Pixel-source handshake and TMDS encoder input bundle for the DVI video sequencer.
// master = sequencer side, slave = pixel source / encoder side.
interface ibis_video_sequencer_if;
   logic [23:0] pixel_rgb;
   logic        pixel_valid;
   logic        pixel_ready;
   logic [7:0]  enc_data_r;
   logic [7:0]  enc_data_g;
   logic [7:0]  enc_data_b;
   logic        enc_data_enable;
   logic [1:0]  enc_control_b;
   logic [1:0]  enc_control_g;
   logic [1:0]  enc_control_r;
   logic        enc_reset;

   modport master (
      input  pixel_rgb, pixel_valid,
      output pixel_ready, enc_data_r, enc_data_g, enc_data_b, enc_data_enable,
      output enc_control_b, enc_control_g, enc_control_r, enc_reset
   );

   modport slave (
      output pixel_rgb, pixel_valid,
      input  pixel_ready, enc_data_r, enc_data_g, enc_data_b, enc_data_enable,
      input  enc_control_b, enc_control_g, enc_control_r, enc_reset
   );
endinterface

// File: rtl/ibis_video_sequencer.sv
// Pixel-rate DVI timing sequencer: counts h/v position, pulls pixels, feeds the three
// TMDS encoders, sequences encoder reset and flags pixel underflow.
module ibis_video_sequencer #(
   parameter int unsigned H_ACTIVE  = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_ACTIVE  = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33,
   parameter bit          HSYNC_POL = 1'b0,
   parameter bit          VSYNC_POL = 1'b0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  clear_underflow,
   ibis_video_sequencer_if.master video,
   output logic [11:0]           h_pos,
   output logic [11:0]           v_pos,
   output logic                  frame_start,
   output logic                  underflow
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [11:0] HActive    = 12'(H_ACTIVE);
   localparam logic [11:0] HSyncStart = 12'(H_ACTIVE + H_FRONT);
   localparam logic [11:0] HSyncEnd   = 12'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [11:0] HLast      = 12'(H_TOTAL - 1);
   localparam logic [11:0] VActive    = 12'(V_ACTIVE);
   localparam logic [11:0] VSyncStart = 12'(V_ACTIVE + V_FRONT);
   localparam logic [11:0] VSyncEnd   = 12'(V_ACTIVE + V_FRONT + V_SYNC);
   localparam logic [11:0] VLast      = 12'(V_TOTAL - 1);

   typedef enum logic [0:0] {StStartup, StRun} state_t;

   state_t      state;
   logic        startup_seen;
   logic        active;
   logic        h_wrap;
   logic [11:0] h_next;
   logic [11:0] v_next;
   logic        hsync_next;
   logic        vsync_next;

   always_comb begin
      active     = (h_pos < HActive) && (v_pos < VActive);
      h_wrap     = (h_pos == HLast);
      h_next     = h_wrap ? 12'd0 : h_pos + 12'd1;
      v_next     = v_pos;
      if (h_wrap) begin
         v_next = (v_pos == VLast) ? 12'd0 : v_pos + 12'd1;
      end
      // Encoder registers control one step early, so sync looks one pixel ahead.
      hsync_next = (h_next >= HSyncStart) && (h_next < HSyncEnd);
      vsync_next = (v_next >= VSyncStart) && (v_next < VSyncEnd);
   end

   assign video.pixel_ready   = (state == StRun) && enable && active;
   assign video.enc_control_g = 2'b00;
   assign video.enc_control_r = 2'b00;

   always_ff @(posedge clock) begin
      if (reset) begin
         state                 <= StStartup;
         startup_seen          <= 1'b0;
         h_pos                 <= 12'd0;
         v_pos                 <= 12'd0;
         video.enc_reset       <= 1'b1;
         video.enc_data_r      <= 8'h00;
         video.enc_data_g      <= 8'h00;
         video.enc_data_b      <= 8'h00;
         video.enc_data_enable <= 1'b0;
         video.enc_control_b   <= {~VSYNC_POL, ~HSYNC_POL};
         frame_start           <= 1'b0;
         underflow             <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         if (clear_underflow) begin
            underflow <= 1'b0;
         end
         if (enable) begin
            unique case (state)
               StStartup: begin
                  if (startup_seen) begin
                     state           <= StRun;
                     video.enc_reset <= 1'b0;
                  end else begin
                     startup_seen <= 1'b1;
                  end
               end
               StRun: begin
                  h_pos                 <= h_next;
                  v_pos                 <= v_next;
                  video.enc_data_enable <= active;
                  if (active && video.pixel_valid) begin
                     video.enc_data_r <= video.pixel_rgb[23:16];
                     video.enc_data_g <= video.pixel_rgb[15:8];
                     video.enc_data_b <= video.pixel_rgb[7:0];
                  end else begin
                     video.enc_data_r <= 8'h00;
                     video.enc_data_g <= 8'h00;
                     video.enc_data_b <= 8'h00;
                  end
                  // Placed after the clear so a same-cycle set wins.
                  if (active && !video.pixel_valid) begin
                     underflow <= 1'b1;
                  end
                  video.enc_control_b <= {vsync_next ? VSYNC_POL : ~VSYNC_POL,
                                          hsync_next ? HSYNC_POL : ~HSYNC_POL};
                  frame_start         <= (h_pos == 12'd0) && (v_pos == 12'd0);
               end
               default: state <= StStartup;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ibis_video_sequencer.sv
// Randomized bench for ibis_video_sequencer on a shrunken timing, checked against a
// step-count reference model (position = steps mod line/frame length).
module tb_ibis_video_sequencer;

   localparam int HA = 8, HF = 2, HS = 3, HB = 2;
   localparam int VA = 4, VF = 1, VS = 2, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam bit HP = 1'b1;
   localparam bit VP = 1'b0;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b1;
   logic        clear_underflow = 1'b0;
   logic [11:0] h_pos;
   logic [11:0] v_pos;
   logic        frame_start;
   logic        underflow;

   ibis_video_sequencer_if vif();

   ibis_video_sequencer #(
      .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .HSYNC_POL(HP), .VSYNC_POL(VP)
   ) dut (
      .clock(clock),
      .reset(reset),
      .enable(enable),
      .clear_underflow(clear_underflow),
      .video(vif),
      .h_pos(h_pos),
      .v_pos(v_pos),
      .frame_start(frame_start),
      .underflow(underflow)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: enables seen since reset, and counting steps taken in RUN.
   int          en_seen;
   int          steps;
   logic [23:0] exp_data;
   bit          exp_de, exp_fs, exp_uf, exp_rst;
   logic [1:0]  exp_ctl;

   function automatic bit act_at(int k);
      return ((k % HT) < HA) && (((k / HT) % VT) < VA);
   endfunction

   function automatic logic [1:0] ctl_at(int k);
      int h = k % HT;
      int v = (k / HT) % VT;
      bit hs = (h >= HA + HF) && (h < HA + HF + HS);
      bit vs = (v >= VA + VF) && (v < VA + VF + VS);
      return {vs ? VP : !VP, hs ? HP : !HP};
   endfunction

   task automatic model_reset();
      en_seen  = 0;
      steps    = 0;
      exp_data = 24'h0;
      exp_de   = 1'b0;
      exp_fs   = 1'b0;
      exp_uf   = 1'b0;
      exp_rst  = 1'b1;
      exp_ctl  = {!VP, !HP};
   endtask

   task automatic model_edge(input bit r, input bit e, input bit vld, input bit clr,
                             input logic [23:0] rgb);
      bit act;
      if (r) begin
         model_reset();
      end else begin
         exp_fs = 1'b0;
         if (clr) exp_uf = 1'b0;
         if (e && en_seen < 2) begin
            en_seen++;
            exp_rst = (en_seen < 2);
         end else if (e) begin
            act    = act_at(steps);
            exp_de = act;
            if (act) begin
               exp_data = vld ? rgb : 24'h0;
               if (!vld) exp_uf = 1'b1;
            end
            exp_ctl = ctl_at(steps + 1);
            exp_fs  = (steps % (HT * VT)) == 0;
            steps++;
         end
      end
   endtask

   task automatic cycle(input bit r, input bit e, input bit vld, input bit clr,
                        input logic [23:0] rgb);
      @(negedge clock);
      reset           = r;
      enable          = e;
      vif.pixel_valid = vld;
      vif.pixel_rgb   = rgb;
      clear_underflow = clr;
      #1;
      check("pixel_ready", vif.pixel_ready, (en_seen >= 2) && e && act_at(steps));
      @(posedge clock);
      model_edge(r, e, vld, clr, rgb);
      #1;
      check("h_pos", h_pos, (steps % HT));
      check("v_pos", v_pos, ((steps / HT) % VT));
      check("enc_reset", vif.enc_reset, exp_rst);
      check("data_enable", vif.enc_data_enable, exp_de);
      check("control_b", vif.enc_control_b, exp_ctl);
      check("control_gr", {vif.enc_control_g, vif.enc_control_r}, 4'h0);
      check("frame_start", frame_start, exp_fs);
      check("underflow", underflow, exp_uf);
      if (exp_de || r) begin
         check("data", {vif.enc_data_r, vif.enc_data_g, vif.enc_data_b}, exp_data);
      end
   endtask

   initial begin
      int fs_prev = -1;
      int de_count = 0;
      int hs_run = 0;
      int guard;
      model_reset();
      vif.pixel_valid = 1'b1;
      vif.pixel_rgb   = 24'h0;
      repeat (2) @(posedge clock);
      cycle(1, 1, 1, 0, 24'h0);

      // Continuous enable: frame length, active pixels per frame, hsync width.
      for (int i = 0; i < 3 * HT * VT + 5; i++) begin
         cycle(0, 1, $urandom_range(0, 19) != 0, $urandom_range(0, 49) == 0, $urandom());
         if (frame_start) begin
            if (fs_prev >= 0) begin
               check("frame_gap", i - fs_prev, HT * VT);
               check("de_per_frame", de_count, HA * VA);
            end
            fs_prev  = i;
            de_count = 0;
         end
         if (vif.enc_data_enable) de_count++;
         if (vif.enc_control_b[0] == HP) begin
            hs_run++;
         end else begin
            if (hs_run > 0) check("hsync_width", hs_run, HS);
            hs_run = 0;
         end
      end

      // Directed underflow in the active area, then clear during blanking.
      guard = 0;
      while ((steps % (HT * VT)) != 2 * HT + 5 && guard < 400) begin
         cycle(0, 1, 1, 0, $urandom());
         guard++;
      end
      check("seek_underflow", guard < 400, 1);
      cycle(0, 1, 0, 0, 24'hABCDEF);
      check("uf_set", underflow, 1);
      repeat (6) cycle(0, 1, 1, 0, $urandom());
      cycle(0, 1, 1, 1, $urandom());
      check("uf_clear", underflow, 0);

      // Sparse enable: one strobe in four on average.
      for (int i = 0; i < 600; i++) begin
         cycle(0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) != 0,
               $urandom_range(0, 59) == 0, $urandom());
      end

      // Reset in the middle of an active line.
      guard = 0;
      while ((steps % (HT * VT)) != 2 * HT + 6 && guard < 400) begin
         cycle(0, 1, 1, 0, $urandom());
         guard++;
      end
      check("seek_reset", guard < 400, 1);
      cycle(1, 1, 1, 0, 24'h123456);

      // Mixed traffic with occasional resets.
      for (int i = 0; i < 800; i++) begin
         cycle($urandom_range(0, 149) == 0, $urandom_range(0, 1) == 1,
               $urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0, $urandom());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
